// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle; 33 cycles from accept to result.
module mult_div_unit (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        WriteHi,
  input  logic        WriteLo,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [4:0]  cnt;
  logic        is_div, is_sgn;
  logic        neg_a, neg_b, dz;
  logic [31:0] opb;
  logic [63:0] acc;

  logic        accept;
  logic        sgn_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, shifted, sub_try;
  logic [63:0] mul_nx, div_nx;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;
  logic [31:0] hi_res, lo_res;

  assign accept = (state == IDLE) && Start;
  assign Busy   = (state != IDLE);

  // operand magnitudes taken at acceptance
  assign sgn_in = ~Op[0];
  assign mag_a  = (sgn_in && SrcA[31]) ? -SrcA : SrcA;
  assign mag_b  = (sgn_in && SrcB[31]) ? -SrcB : SrcB;

  // shift-add multiply step: low half holds remaining multiplier bits
  assign add_sum = {1'b0, acc[63:32]}
                 + {1'b0, (acc[0] ? opb : 32'd0)};
  assign mul_nx  = {add_sum, acc[31:1]};

  // restoring divide step: upper half remainder, lower half dividend/quotient
  assign shifted = {acc[63:32], acc[31]};
  assign sub_try = shifted - {1'b0, opb};
  assign div_nx  = sub_try[32]
                 ? {shifted[31:0], acc[30:0], 1'b0}
                 : {sub_try[31:0], acc[30:0], 1'b1};

  // sign correction applied when results are committed
  assign prod_fix = (is_sgn && (neg_a ^ neg_b)) ? -acc : acc;
  assign q_fix    = (is_sgn && (neg_a ^ neg_b))
                  ? -acc[31:0] : acc[31:0];
  assign r_fix    = (is_sgn && neg_a) ? -acc[63:32] : acc[63:32];
  assign hi_res   = is_div ? r_fix : prod_fix[63:32];
  assign lo_res   = is_div ? (dz ? 32'hFFFF_FFFF : q_fix)
                           : prod_fix[31:0];

  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (Start) state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture and iterative datapath
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt    <= 5'd0;
      is_div <= 1'b0;
      is_sgn <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      opb    <= 32'd0;
      acc    <= 64'd0;
    end else if (accept) begin
      cnt    <= 5'd0;
      is_div <= Op[1];
      is_sgn <= sgn_in;
      neg_a  <= sgn_in && SrcA[31];
      neg_b  <= sgn_in && SrcB[31];
      dz     <= (SrcB == 32'd0);
      opb    <= mag_b;
      acc    <= {32'd0, mag_a};
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      acc <= is_div ? div_nx : mul_nx;
    end
  end

  // HI/LO commit, MTHI/MTLO writes and completion pulse
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      HI   <= 32'd0;
      LO   <= 32'd0;
      Done <= 1'b0;
    end else begin
      Done <= (state == FINISH);
      if (state == FINISH) begin
        HI <= hi_res;
        LO <= lo_res;
      end else if (state == IDLE && !Start) begin
        if (WriteHi) HI <= SrcA;
        if (WriteLo) LO <= SrcA;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Directed cases plus random operations against an arithmetic model.
module tb_mult_div_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB;
  logic        WriteHi, WriteLo;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_hi, cur_lo;

  mult_div_unit dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .Op(Op),
    .SrcA(SrcA), .SrcB(SrcB),
    .WriteHi(WriteHi), .WriteLo(WriteLo),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {HI, LO} from plain arithmetic on the architectural rules
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] sp;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Starts at the current negedge, returns at the negedge of the Done cycle.
  // poke>0: a Start with new operands plus WriteLo is issued mid-run.
  // wr: WriteHi/WriteLo asserted together with Start.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int poke, input bit wr);
    logic [63:0] exp;
    int n, dones;
    bit stable;
    exp = model(op, a, b);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    WriteHi = wr; WriteLo = wr;
    @(negedge CLK);
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    n = 0; dones = 0; stable = 1'b1;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      if (Done === 1'b1) dones++;
      if (HI !== cur_hi || LO !== cur_lo) stable = 1'b0;
      Op = 2'($urandom_range(0, 3));
      SrcA = $urandom;
      SrcB = $urandom;
      if (n == poke) begin
        Start = 1'b1; WriteLo = 1'b1;
      end else begin
        Start = 1'b0; WriteLo = 1'b0;
      end
      @(negedge CLK);
    end
    Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    check({tag, " busy_cycles"}, 32'(n), 32'd33);
    check({tag, " hold"}, {31'd0, stable}, 32'd1);
    check({tag, " early_done"}, 32'(dones), 32'd0);
    check({tag, " busy_end"}, {31'd0, Busy}, 32'd0);
    check({tag, " done"}, {31'd0, Done}, 32'd1);
    check({tag, " hi"}, HI, exp[63:32]);
    check({tag, " lo"}, LO, exp[31:0]);
    cur_hi = exp[63:32];
    cur_lo = exp[31:0];
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    RSTn = 1'b0; Start = 1'b0; Op = 2'd0;
    SrcA = 32'd0; SrcB = 32'd0;
    WriteHi = 1'b0; WriteLo = 1'b0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst busy", {31'd0, Busy}, 32'd0);
    check("rst done", {31'd0, Done}, 32'd0);
    check("rst hi", HI, 32'd0);
    check("rst lo", LO, 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    // MTHI / MTLO in IDLE
    WriteHi = 1'b1; SrcA = 32'hCAFE_F00D;
    @(negedge CLK);
    WriteHi = 1'b0;
    check("mthi hi", HI, 32'hCAFE_F00D);
    check("mthi lo", LO, 32'd0);
    WriteLo = 1'b1; SrcA = 32'h1111_2222;
    @(negedge CLK);
    WriteLo = 1'b0;
    check("mtlo lo", LO, 32'h1111_2222);
    check("mtlo hi", HI, 32'hCAFE_F00D);
    WriteHi = 1'b1; WriteLo = 1'b1; SrcA = 32'h5A5A_A5A5;
    @(negedge CLK);
    WriteHi = 1'b0; WriteLo = 1'b0;
    check("mtboth hi", HI, 32'h5A5A_A5A5);
    check("mtboth lo", LO, 32'h5A5A_A5A5);
    cur_hi = 32'h5A5A_A5A5; cur_lo = 32'h5A5A_A5A5;

    run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    @(negedge CLK);
    check("multu done_pulse", {31'd0, Done}, 32'd0);
    check("multu hi_const", HI, 32'hFFFF_FFFE);
    check("multu lo_const", LO, 32'h0000_0001);

    run_op("mult neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 0, 1'b1);
    check("mult lo_const", LO, 32'hFFFF_FFF1);
    @(negedge CLK);
    run_op("div neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("div q_const", LO, 32'hFFFF_FFFD);
    check("div r_const", HI, 32'hFFFF_FFFF);
    run_op("divu poke", 2'd3, 32'd100, 32'd7, 5, 1'b0);
    check("divu q_const", LO, 32'd14);
    check("divu r_const", HI, 32'd2);
    run_op("div zero", 2'd2, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("divu zero", 2'd3, 32'h8765_4321, 32'd0, 0, 1'b0);
    run_op("div negzero", 2'd2, 32'hF000_0001, 32'd0, 0, 1'b0);
    @(negedge CLK);

    // reset in the middle of a divide
    Start = 1'b1; Op = 2'd3; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("midrst busy", {31'd0, Busy}, 32'd0);
    check("midrst done", {31'd0, Done}, 32'd0);
    check("midrst hi", HI, 32'd0);
    check("midrst lo", LO, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    cur_hi = 32'd0; cur_lo = 32'd0;
    @(negedge CLK);
    run_op("post rst", 2'd1, 32'd3, 32'd4, 0, 1'b0);
    check("post lo_const", LO, 32'd12);

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(8, 31);
      if (i % 6 == 5) rb = 32'd0;
      if (i % 4 == 2) ra = -ra;
      run_op("rand", rop, ra, rb, (i % 3 == 0) ? 7 : 0, i[0]);
      if (i % 2 == 1) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
